// File: rtl/aes_key_expander_if.sv
// +----------------------------------------------------------------------+
// | aes_key_expander_if                                                  |
// | Request / round-key stream bundle for the AES key expander.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface aes_key_expander_if;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   key_len;
  logic [255:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_last;
  logic         busy;
  logic         err;

  modport master (
    output in_valid, key_len, key, out_ready,
    input  in_ready, out_valid, out_key, out_round, out_last, busy, err
  );

  modport slave (
    input  in_valid, key_len, key, out_ready,
    output in_ready, out_valid, out_key, out_round, out_last, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/aes_key_expander.sv
// +----------------------------------------------------------------------+
// | aes_key_expander                                                     |
// | Streams AES-128/192/256 round keys, one 32-bit word per cycle.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module aes_key_expander #(
  parameter bit EN_128 = 1'b1,
  parameter bit EN_192 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  aes_key_expander_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GEN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [2047:0] c_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Table is stored with entry 0x00 in the top byte.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    sbox = c_SBOX[{~a, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  state_t       r_state;
  logic [31:0]  r_win [0:7];
  logic [31:0]  r_asm [0:2];
  logic [3:0]   r_nk;
  logic [3:0]   r_nr;
  logic [5:0]   r_idx;
  logic [3:0]   r_kmod;
  logic [7:0]   r_rcon;
  logic [127:0] r_out_key;
  logic [3:0]   r_out_round;
  logic         r_out_valid;
  logic         r_out_last;
  logic         r_err;

  logic         w_accept;
  logic         w_len_ok;
  logic [3:0]   w_nk;
  logic [3:0]   w_nr;
  logic         w_stall;
  logic         w_gen;
  logic         w_load;
  logic         w_from_key;
  logic         w_use_rcon;
  logic         w_is_final;
  logic [2:0]   w_prev_sel;
  logic [31:0]  w_prev;
  logic [31:0]  w_t;
  logic [31:0]  w_new;
  logic [7:0]   w_rcon_next;

  assign w_accept = bus.in_valid && bus.in_ready;

  always_comb begin
    w_len_ok = 1'b0;
    w_nk     = 4'd8;
    w_nr     = 4'd14;
    case (bus.key_len)
      2'b00: begin w_len_ok = EN_128; w_nk = 4'd4; w_nr = 4'd10; end
      2'b01: begin w_len_ok = EN_192; w_nk = 4'd6; w_nr = 4'd12; end
      2'b10: begin w_len_ok = 1'b1;   w_nk = 4'd8; w_nr = 4'd14; end
      default: w_len_ok = 1'b0;
    endcase
  end

  // Only the word that completes a round key needs the output register free.
  assign w_stall    = r_out_valid && !bus.out_ready && (r_idx[1:0] == 2'd3);
  assign w_gen      = (r_state == S_GEN) && !w_stall;
  assign w_load     = w_gen && (r_idx[1:0] == 2'd3);
  assign w_from_key = (r_idx < {2'b00, r_nk});
  assign w_use_rcon = !w_from_key && (r_kmod == 4'd0);
  assign w_is_final = (r_idx == {r_nr, 2'b11});
  assign w_prev_sel = 3'(r_nk - 4'd1);
  assign w_prev     = r_win[w_prev_sel];

  always_comb begin
    w_t = w_prev;
    if (r_kmod == 4'd0)
      w_t = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h000000};
    else if ((r_nk == 4'd8) && (r_kmod == 4'd4))
      w_t = sub_word(w_prev);
  end

  assign w_new       = w_from_key ? r_win[r_idx[2:0]] : (r_win[0] ^ w_t);
  assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_idx       <= 6'd0;
      r_kmod      <= 4'd0;
      r_rcon      <= 8'h01;
      r_nk        <= 4'd4;
      r_nr        <= 4'd10;
      r_out_key   <= 128'd0;
      r_out_round <= 4'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_len_ok) begin
              for (int k = 0; k < 8; k++)
                r_win[k] <= bus.key[255 - 32*k -: 32];
              r_nk    <= w_nk;
              r_nr    <= w_nr;
              r_idx   <= 6'd0;
              r_kmod  <= 4'd0;
              r_rcon  <= 8'h01;
              r_state <= S_GEN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_GEN: begin
          if (w_gen) begin
            r_idx  <= r_idx + 6'd1;
            r_kmod <= (r_kmod == r_nk - 4'd1) ? 4'd0 : r_kmod + 4'd1;
            if (w_use_rcon)
              r_rcon <= w_rcon_next;
            // Window keeps w[i-Nk..i-1] in slots 0..Nk-1 once past the key words.
            if (!w_from_key) begin
              for (int k = 0; k < 7; k++)
                r_win[k] <= r_win[k + 1];
              r_win[w_prev_sel] <= w_new;
            end
            if (!w_load)
              r_asm[r_idx[1:0]] <= w_new;
            if (w_load && w_is_final)
              r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_out_valid && bus.out_ready && r_out_last)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_load) begin
        r_out_key   <= {r_asm[0], r_asm[1], r_asm[2], w_new};
        r_out_round <= r_idx[5:2];
        r_out_last  <= w_is_final;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rst && (r_state == S_IDLE);
  assign bus.busy      = rst && (r_state != S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_key   = r_out_key;
  assign bus.out_round = r_out_round;
  assign bus.out_last  = r_out_last;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expander.sv
// +----------------------------------------------------------------------+
// | tb_aes_key_expander                                                  |
// | Directed FIPS-197 vectors, stalls, error and reset cases.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_aes_key_expander;

  logic clk = 1'b0;
  logic rst = 1'b0;

  aes_key_expander_if bus ();
  aes_key_expander_if bus2 ();

  aes_key_expander #(.EN_128(1'b1), .EN_192(1'b1)) dut  (.clk(clk), .rst(rst), .bus(bus));
  aes_key_expander #(.EN_128(1'b1), .EN_192(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [255:0] c_KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] c_KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] c_KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] exp128 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  int n_asrt = 0;
  int n_fail = 0;

  logic [127:0] got_key   [0:15];
  int           got_round [0:15];
  logic         got_last  [0:15];
  int           got_cyc   [0:15];
  int           nkeys, stall_bad, seq_bad, lat_bad, seen;
  bit           done;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request at the current negedge and collects round keys until out_last.
  task automatic run(input logic [1:0] kl, input logic [255:0] k, input bit rnd, input int nr_exp);
    int  acc;
    bit  pv, pr, pl;
    logic [127:0] pk;
    logic [3:0]   prd;
    bus.key_len   = kl;
    bus.key       = k;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    acc = cyc;
    nkeys = 0; stall_bad = 0; seq_bad = 0; lat_bad = 0; done = 1'b0;
    pv = 1'b0; pr = 1'b1; pl = 1'b0; pk = '0; prd = '0;
    for (int t = 0; t < 400 && !done; t++) begin
      if (pv && !pr &&
          !(bus.out_valid && bus.out_key == pk && bus.out_round == prd && bus.out_last == pl))
        stall_bad++;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        if (nkeys < 16) begin
          got_key[nkeys]   = bus.out_key;
          got_round[nkeys] = int'(bus.out_round);
          got_last[nkeys]  = bus.out_last;
          got_cyc[nkeys]   = cyc - acc;
        end
        nkeys++;
        if (bus.out_last) done = 1'b1;
      end
      pv = bus.out_valid; pr = bus.out_ready; pk = bus.out_key;
      prd = bus.out_round; pl = bus.out_last;
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    for (int r = 0; r < nkeys && r < 16; r++) begin
      if (got_round[r] != r || got_last[r] != (r == nr_exp)) seq_bad++;
      if (!rnd && got_cyc[r] != 4 * (r + 1)) lat_bad++;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.key_len = 2'b00; bus.key = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.key_len = 2'b00; bus2.key = '0; bus2.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_flags", {bus.out_valid, bus.out_last, bus.err, bus.busy, bus.in_ready}, 5'b0);
    chk("rst_key", bus.out_key, 128'd0);
    chk("rst_round", bus.out_round, 4'd0);

    // Request issued on the very first edge with reset released.
    rst = 1'b1;
    run(2'b00, c_KEY128, 1'b0, 10);
    chk("a128_done", done, 1'b1);
    chk("a128_count", nkeys, 11);
    for (int r = 0; r < 11; r++) chk($sformatf("a128_key%0d", r), got_key[r], exp128[r]);
    chk("a128_seq", seq_bad, 0);
    chk("a128_latency", lat_bad, 0);
    chk("a128_idle", {bus.in_ready, bus.busy}, 2'b10);

    run(2'b01, c_KEY192, 1'b0, 12);
    chk("a192_count", nkeys, 13);
    chk("a192_key0", got_key[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    chk("a192_key1", got_key[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    chk("a192_key12", got_key[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("a192_seq", seq_bad, 0);
    chk("a192_latency", lat_bad, 0);

    run(2'b10, c_KEY256, 1'b0, 14);
    chk("a256_count", nkeys, 15);
    chk("a256_key1", got_key[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("a256_key2", got_key[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("a256_key14", got_key[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("a256_seq", seq_bad, 0);
    chk("a256_latency", lat_bad, 0);

    run(2'b10, c_KEY256, 1'b1, 14);
    chk("stall_count", nkeys, 15);
    chk("stall_seq", seq_bad, 0);
    chk("stall_stable", stall_bad, 0);
    chk("stall_key0", got_key[0], c_KEY256[255:128]);
    chk("stall_key2", got_key[2], 128'h9ba354118e6925afa51a8b5f2067fcde);
    chk("stall_key14", got_key[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("stall_idle", {bus.in_ready, bus.busy}, 2'b10);

    bus.key_len = 2'b11; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("err11_pulse", {bus.err, bus.out_valid, bus.in_ready, bus.busy}, 4'b1010);
    @(negedge clk);
    chk("err11_clear", bus.err, 1'b0);
    seen = 0;
    repeat (8) begin @(negedge clk); if (bus.out_valid || bus.busy) seen++; end
    chk("err11_no_output", seen, 0);

    bus2.key_len = 2'b01; bus2.key = c_KEY192; bus2.in_valid = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    chk("err192_pulse", {bus2.err, bus2.out_valid, bus2.in_ready, bus2.busy}, 4'b1010);
    @(negedge clk);
    chk("err192_clear", bus2.err, 1'b0);

    // Abort a 256-bit expansion mid-flight, then run a fresh AES-128 request.
    bus.key_len = 2'b10; bus.key = c_KEY256; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_flags", {bus.out_valid, bus.out_last, bus.err, bus.busy, bus.in_ready}, 5'b0);
    chk("midrst_key", bus.out_key, 128'd0);
    rst = 1'b1;
    run(2'b00, c_KEY128, 1'b0, 10);
    chk("midrst_count", nkeys, 11);
    seen = 0;
    for (int r = 0; r < 11; r++) if (got_key[r] !== exp128[r]) seen++;
    chk("midrst_keys", seen, 0);
    chk("midrst_seq", seq_bad, 0);
    chk("midrst_latency", lat_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
